alu_seq: RTL and testbench

Parametrised, handshaked successor to the combinational execute-stage ALU. It keeps the existing 4-bit `EX_command` encodings and `{Z,C,N,V}` status ordering, and adds the following:
- a WIDTH parameter;
- an internal registered status register, used as the carry source for ADC/SBC;
- a multi-cycle shift-add multiply (MUL);
- valid/ready flow control on both sides;
- a synchronous flush.

It sits in the EX stage between the ID/EX register and the EX/MEM register. The pipeline stalls on `in_ready` low.

---
 rtl/alu_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Handshaked execute-stage ALU. Single-cycle ops load the output
//             register at the acceptance edge. MUL is a WIDTH-cycle shift-add
//             that shares the same output register. The status register
//             {Z,C,N,V} lives here and feeds the carry-in of ADC/SBC.
//  Ports    : clk, rst_n (async, active-low), flush (sync abort)
//             in_valid/in_ready  : upstream handshake (EX_command, s_bit,
//                                  val1, val2 captured on accept)
//             out_valid/out_ready: downstream handshake (res, res_wb)
//             SR                 : registered status {Z,C,N,V}
//             busy               : multiply in progress
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       EX_command,
  input  logic             s_bit,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             res_wb,
  output logic [3:0]       SR,
  output logic             busy
);

  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_LDS = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;
  localparam logic [3:0] OP_CMP = 4'b1100;
  localparam logic [3:0] OP_TST = 4'b1110;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t             state_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   res_q;
  logic               res_wb_q;
  logic [3:0]         sr_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               mul_s_q;

  logic               out_free;
  logic               accept;

  // Single-cycle datapath
  logic               cin;
  logic               bin;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     dif;
  logic               add_v;
  logic               sub_v;
  logic [WIDTH-1:0]   alu_res_d;
  logic               alu_wb_d;
  logic               alu_upd_d;
  logic               alu_c_d;
  logic               alu_v_d;
  logic [3:0]         alu_sr_d;

  // Multiply datapath
  logic [WIDTH-1:0]   acc_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [3:0]         mul_sr_d;

  assign out_free = !out_valid_q | out_ready;
  assign in_ready = (state_q == S_IDLE) & !flush & out_free;
  assign accept   = in_valid & in_ready;

  // Carry-in for ADC is SR.C; borrow-in for SBC is the inverse of SR.C.
  assign cin = (EX_command == OP_ADC) & sr_q[2];
  assign bin = (EX_command == OP_SBC) & ~sr_q[2];
  assign sum = {1'b0, val1} + {1'b0, val2} + {{WIDTH{1'b0}}, cin};
  // Bit WIDTH of the extended difference is set exactly when a borrow occurs.
  assign dif = {1'b0, val1} - {1'b0, val2} - {{WIDTH{1'b0}}, bin};

  assign add_v = (val1[WIDTH-1] == val2[WIDTH-1]) & (sum[WIDTH-1] != val1[WIDTH-1]);
  assign sub_v = (val1[WIDTH-1] != val2[WIDTH-1]) & (dif[WIDTH-1] != val1[WIDTH-1]);

  always_comb begin
    alu_res_d = '0;
    alu_wb_d  = 1'b1;
    alu_upd_d = 1'b0;
    alu_c_d   = 1'b0;
    alu_v_d   = 1'b0;
    case (EX_command)
      OP_MOV: begin alu_res_d = val2;        alu_upd_d = 1'b1; end
      OP_MVN: begin alu_res_d = ~val2;       alu_upd_d = 1'b1; end
      OP_ADD, OP_ADC: begin
        alu_res_d = sum[WIDTH-1:0];
        alu_c_d   = sum[WIDTH];
        alu_v_d   = add_v;
        alu_upd_d = 1'b1;
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        alu_res_d = dif[WIDTH-1:0];
        alu_c_d   = ~dif[WIDTH];
        alu_v_d   = sub_v;
        alu_upd_d = 1'b1;
        alu_wb_d  = (EX_command != OP_CMP);
      end
      OP_AND, OP_TST: begin
        alu_res_d = val1 & val2;
        alu_upd_d = 1'b1;
        alu_wb_d  = (EX_command != OP_TST);
      end
      OP_ORR: begin alu_res_d = val1 | val2; alu_upd_d = 1'b1; end
      OP_EOR: begin alu_res_d = val1 ^ val2; alu_upd_d = 1'b1; end
      // Address add never touches flags.
      OP_LDS: alu_res_d = sum[WIDTH-1:0];
      default: alu_res_d = '0;
    endcase
  end

  assign alu_sr_d = {alu_res_d == '0, alu_c_d, alu_res_d[WIDTH-1], alu_v_d};

  // One shift-add step; once the counter is exhausted the accumulator holds.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
    end
  end

  // MUL keeps C and V from the previous status.
  assign mul_sr_d = {acc_d == '0, sr_q[2], acc_d[WIDTH-1], sr_q[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      res_wb_q    <= 1'b0;
      sr_q        <= 4'b0000;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      mul_s_q     <= 1'b0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      // Consume first; a load later in this block overrides it.
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (EX_command == OP_MUL) begin
              mcand_q  <= val1;
              mplier_q <= val2;
              acc_q    <= '0;
              cnt_q    <= CNT_W'(WIDTH);
              mul_s_q  <= s_bit;
              state_q  <= S_MUL;
            end else begin
              res_q       <= alu_res_d;
              res_wb_q    <= alu_wb_d;
              out_valid_q <= 1'b1;
              if (s_bit && alu_upd_d) begin
                sr_q <= alu_sr_d;
              end
            end
          end
        end
        S_MUL: begin
          if (cnt_q != '0) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_d;
          end
          // Load on the edge where the counter hits zero if the slot is free.
          if (cnt_d == '0 && out_free) begin
            res_q       <= acc_d;
            res_wb_q    <= 1'b1;
            out_valid_q <= 1'b1;
            if (mul_s_q) begin
              sr_q <= mul_sr_d;
            end
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign res_wb    = res_wb_q;
  assign SR        = sr_q;
  assign busy      = (state_q == S_MUL);

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Scoreboard bench for alu_seq. The driver pushes the expected
//             {res, res_wb, SR} of every accepted op; a monitor pops and
//             compares whenever an output is consumed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   EX_command = 4'b0000;
  logic         s_bit = 1'b0;
  logic [W-1:0] val1 = '0;
  logic [W-1:0] val2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] res;
  logic         res_wb;
  logic [3:0]   SR;
  logic         busy;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .EX_command(EX_command), .s_bit(s_bit), .val1(val1), .val2(val2),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .res_wb(res_wb), .SR(SR), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         wb;
    logic [3:0]   sr;
  } exp_t;

  exp_t       q[$];
  logic [3:0] m_sr = 4'b0000;
  int         n_tests = 0;
  int         n_fail = 0;
  bit         rand_or = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: opcode semantics computed with wide integer arithmetic.
  function automatic void model(input logic [3:0] c, input logic s,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                inout logic [3:0] sr, output exp_t e);
    longint ua, ub, sa, sb, r, t, k;
    logic   cf, vf, upd, keep;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 0; cf = 0; vf = 0; upd = 1; keep = 0;
    e.wb = 1'b1;
    case (c)
      4'd1:  r = ub;
      4'd9:  r = ~ub;
      4'd2, 4'd3: begin
        k  = (c == 4'd3) ? longint'(sr[2]) : 0;
        r  = ua + ub + k;
        cf = (r >= 64'sh1_0000_0000);
        t  = sa + sb + k;
        vf = (t > 64'sh7FFF_FFFF) || (t < -64'sh8000_0000);
      end
      4'd4, 4'd5, 4'd12: begin
        k  = (c == 4'd5) ? longint'(!sr[2]) : 0;
        r  = ua - ub - k;
        cf = (ua >= ub + k);
        t  = sa - sb - k;
        vf = (t > 64'sh7FFF_FFFF) || (t < -64'sh8000_0000);
        e.wb = (c != 4'd12);
      end
      4'd6, 4'd14: begin r = ua & ub; e.wb = (c != 4'd14); end
      4'd7:  r = ua | ub;
      4'd8:  r = ua ^ ub;
      4'd10: begin r = ua + ub; upd = 0; end
      4'd11: begin r = ua * ub; keep = 1; end
      default: begin r = 0; upd = 0; end
    endcase
    e.res = r[W-1:0];
    if (s && upd) begin
      sr = {e.res == '0, keep ? sr[2] : cf, e.res[W-1], keep ? sr[0] : vf};
    end
    e.sr = sr;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op; returns the number of cycles spent waiting for in_ready.
  task automatic issue(input logic [3:0] c, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int waited);
    exp_t e;
    bit   done;
    EX_command = c; s_bit = s; val1 = a; val2 = b; in_valid = 1'b1;
    waited = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        model(c, s, a, b, m_sr, e);
        q.push_back(e);
        done = 1'b1;
      end
      tick();
      if (!done) begin
        waited++;
        if (waited > 200) begin
          check("issue_timeout", 64'd1, 64'd0);
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input int max);
    int n = 0;
    while (!out_valid && n < max) begin
      tick();
      n++;
    end
    if (!out_valid) check(name, 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      tick();
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("sb_unexpected_output", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check("sb_res", 64'(res), 64'(e.res));
        check("sb_res_wb", 64'(res_wb), 64'(e.wb));
        check("sb_sr", 64'(SR), 64'(e.sr));
      end
    end
  end

  // Random backpressure
  initial begin
    forever begin
      tick();
      if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int           w;
    int           busy_cnt;
    int           lat;
    logic [3:0]   saved;
    logic [3:0]   c;
    logic [3:0]   ops [0:15];

    ops = '{4'd1, 4'd9, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
            4'd8, 4'd12, 4'd14, 4'd10, 4'd11, 4'd0, 4'd13, 4'd15};

    repeat (3) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_res", 64'(res), 64'd0);
    check("rst_res_wb", 64'(res_wb), 64'd0);
    check("rst_sr", 64'(SR), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;

    issue(4'd2, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, w);
    check("add_ovf_valid", 64'(out_valid), 64'd1);
    check("add_ovf_res", 64'(res), 64'h8000_0000);
    check("add_ovf_sr", 64'(SR), 64'b0011);

    issue(4'd4, 1'b1, 32'd5, 32'd5, w);
    check("sub_eq_sr", 64'(SR), 64'b1100);
    issue(4'd12, 1'b1, 32'd3, 32'd7, w);
    check("cmp_sr", 64'(SR), 64'b0010);
    check("cmp_wb", 64'(res_wb), 64'd0);
    check("cmp_res", 64'(res), 64'hFFFF_FFFC);

    issue(4'd2, 1'b1, 32'hFFFF_FFFF, 32'd1, w);
    check("add_carry_sr", 64'(SR), 64'b1100);
    tick();
    issue(4'd3, 1'b0, 32'd2, 32'd3, w);
    check("adc_res", 64'(res), 64'd6);

    issue(4'd11, 1'b1, 32'h0001_0000, 32'h0001_0000, w);
    busy_cnt = 0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (busy && !in_ready) busy_cnt++;
      tick();
      lat++;
    end
    check("mul_latency", 64'(lat), 64'd32);
    check("mul_busy_cycles", 64'(busy_cnt), 64'd32);
    check("mul_busy_done", 64'(busy), 64'd0);
    check("mul_zero_res", 64'(res), 64'd0);
    check("mul_zero_sr", 64'(SR), 64'b1100);

    issue(4'd11, 1'b0, 32'd123, 32'd456, w);
    wait_out("mul2_timeout", 100);
    check("mul2_res", 64'(res), 64'd56088);
    drain();

    out_ready = 1'b0;
    issue(4'd2, 1'b0, 32'd10, 32'd20, w);
    repeat (3) begin
      tick();
      check("bp_res", 64'(res), 64'd30);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    issue(4'd8, 1'b0, 32'hF0F0_0000, 32'h0FF0_FFFF, w);
    check("bp_release_wait", 64'(w), 64'd0);
    drain();

    issue(4'd11, 1'b1, 32'd77, 32'd99, w);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_res", 64'(res), 64'd0);
    check("mrst_wb", 64'(res_wb), 64'd0);
    check("mrst_sr", 64'(SR), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    q.delete();
    m_sr = 4'b0000;
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("mrst_no_output", 64'(out_valid), 64'd0);

    issue(4'd2, 1'b1, 32'hFFFF_FFFF, 32'd1, w);
    drain();
    saved = m_sr;
    issue(4'd11, 1'b1, 32'd3, 32'd5, w);
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_sr", 64'(SR), 64'(saved));
    q.delete();
    m_sr = saved;
    repeat (40) tick();
    check("flush_no_output", 64'(out_valid), 64'd0);
    issue(4'd3, 1'b1, 32'd1, 32'd1, w);
    drain();

    rand_or = 1'b1;
    for (int i = 0; i < 300; i++) begin
      c = ops[$urandom_range(0, 15)];
      issue(c, 1'(($urandom_range(0, 3)) != 0), pick_val(), pick_val(), w);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_or = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
